mfcc_frame_packer: RTL and testbench

MFCC_FRAME_PACKER -- requirements
Module: mfcc_frame_packer

---
 rtl/mfcc_frame_packer.sv | 200 ++++++++++++++++++++
 tb/tb_mfcc_frame_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mfcc_frame_packer: ping-pong MFCC banks packed into framed bytes  Rev 1.0 |
// +--------------------------------------------------------------------------+
module mfcc_frame_packer #(
  parameter int         NUM_CEPS   = 12,
  parameter int         CEPS_WIDTH = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        dct_valid_i,
  input  logic [$clog2(NUM_CEPS)-1:0] ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0]       ceps_i,
  input  logic                        dct_done_i,
  output logic [7:0]                  byte_o,
  output logic                        byte_valid_o,
  input  logic                        byte_ready_i,
  output logic [15:0]                 frame_count_o,
  output logic                        overflow_o,
  output logic                        busy_o
);
  localparam int               PTR_W    = $clog2(NUM_CEPS);
  localparam logic [PTR_W:0]   PTR_LIM  = (PTR_W+1)'(NUM_CEPS);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CEPS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA_HI, DATA_LO, CHK} state_t;
  state_t state_q, state_d;

  logic [CEPS_WIDTH-1:0] bank_q [2][NUM_CEPS];
  logic [CEPS_WIDTH-1:0] bank_d [2][NUM_CEPS];
  logic [CEPS_WIDTH-1:0] tx_q [NUM_CEPS];
  logic [CEPS_WIDTH-1:0] tx_d [NUM_CEPS];
  logic [7:0]            seq_q [2];
  logic [7:0]            seq_d [2];
  logic [1:0]            pend_q, pend_d;
  logic                  wr_sel_q, wr_sel_d;
  logic [7:0]            tx_seq_q, tx_seq_d, csum_q, csum_d, byte_q, byte_d;
  logic [PTR_W-1:0]      idx_q, idx_d, idx_nx;
  logic [15:0]           fc_q, fc_d;
  logic                  ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;

  logic other_sel, accept, chk_acc, can_launch, launch_pend, launch_new;
  logic other_free, commit, drop, ptr_ok;

  assign other_sel   = ~wr_sel_q;
  assign accept      = valid_q & byte_ready_i;
  assign chk_acc     = (state_q == CHK) & accept;
  assign can_launch  = (state_q == IDLE) | chk_acc;
  assign launch_pend = can_launch & pend_q[other_sel];
  // A pending bank leaving for the transmit buffer this cycle counts as free.
  assign other_free  = ~pend_q[other_sel] | launch_pend;
  assign commit      = dct_done_i & other_free;
  assign drop        = dct_done_i & ~other_free;
  assign launch_new  = can_launch & ~pend_q[other_sel] & commit;
  assign ptr_ok      = ({1'b0, ceps_ptr_i} < PTR_LIM);
  assign idx_nx      = idx_q + PTR_W'(1);

  always_comb begin
    for (int b = 0; b < 2; b++) begin
      seq_d[b] = seq_q[b];
      for (int k = 0; k < NUM_CEPS; k++) bank_d[b][k] = bank_q[b][k];
    end
    for (int k = 0; k < NUM_CEPS; k++) tx_d[k] = tx_q[k];
    pend_d   = pend_q;
    tx_seq_d = tx_seq_q;
    wr_sel_d = wr_sel_q;
    fc_d     = fc_q;
    ovf_d    = ovf_q;

    if (dct_valid_i && ptr_ok) bank_d[wr_sel_q][ceps_ptr_i] = ceps_i;
    if (chk_acc)
      for (int k = 0; k < NUM_CEPS; k++) tx_d[k] = '0;
    if (launch_pend) begin
      for (int k = 0; k < NUM_CEPS; k++) begin
        tx_d[k]              = bank_q[other_sel][k];
        bank_d[other_sel][k] = '0;
      end
      tx_seq_d          = seq_q[other_sel];
      pend_d[other_sel] = 1'b0;
    end
    if (commit) begin
      seq_d[wr_sel_q] = fc_q[7:0];
      fc_d            = fc_q + 16'd1;
      wr_sel_d        = ~wr_sel_q;
      // Idle transmitter takes the frame directly, including this cycle's sample.
      if (launch_new) begin
        for (int k = 0; k < NUM_CEPS; k++) begin
          tx_d[k]             = bank_d[wr_sel_q][k];
          bank_d[wr_sel_q][k] = '0;
        end
        tx_seq_d = fc_q[7:0];
      end else begin
        pend_d[wr_sel_q] = 1'b1;
      end
    end
    if (drop) begin
      ovf_d = 1'b1;
      for (int k = 0; k < NUM_CEPS; k++) bank_d[wr_sel_q][k] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: if (launch_pend || launch_new) begin
        state_d = SYNC;
        byte_d  = SYNC_BYTE;
      end
      SYNC: if (accept) begin
        state_d = SEQ;
        byte_d  = tx_seq_q;
        csum_d  = tx_seq_q;
      end
      SEQ: if (accept) begin
        state_d = DATA_HI;
        idx_d   = '0;
        byte_d  = tx_q[0][CEPS_WIDTH-1:8];
        csum_d  = csum_q ^ tx_q[0][CEPS_WIDTH-1:8];
      end
      DATA_HI: if (accept) begin
        state_d = DATA_LO;
        byte_d  = tx_q[idx_q][7:0];
        csum_d  = csum_q ^ tx_q[idx_q][7:0];
      end
      DATA_LO: if (accept) begin
        if (idx_q == LAST_IDX) begin
          state_d = CHK;
          byte_d  = csum_q;
        end else begin
          state_d = DATA_HI;
          idx_d   = idx_nx;
          byte_d  = tx_q[idx_nx][CEPS_WIDTH-1:8];
          csum_d  = csum_q ^ tx_q[idx_nx][CEPS_WIDTH-1:8];
        end
      end
      CHK: if (accept) begin
        if (launch_pend || launch_new) begin
          state_d = SYNC;
          byte_d  = SYNC_BYTE;
        end else begin
          state_d = IDLE;
          byte_d  = 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d != IDLE);
    busy_d  = (|pend_d) | valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      wr_sel_q <= 1'b0;
      tx_seq_q <= '0;
      csum_q   <= '0;
      byte_q   <= '0;
      idx_q    <= '0;
      fc_q     <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        seq_q[b] <= '0;
        for (int k = 0; k < NUM_CEPS; k++) bank_q[b][k] <= '0;
      end
      for (int k = 0; k < NUM_CEPS; k++) tx_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      wr_sel_q <= wr_sel_d;
      tx_seq_q <= tx_seq_d;
      csum_q   <= csum_d;
      byte_q   <= byte_d;
      idx_q    <= idx_d;
      fc_q     <= fc_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      for (int b = 0; b < 2; b++) begin
        seq_q[b] <= seq_d[b];
        for (int k = 0; k < NUM_CEPS; k++) bank_q[b][k] <= bank_d[b][k];
      end
      for (int k = 0; k < NUM_CEPS; k++) tx_q[k] <= tx_d[k];
    end
  end

  assign byte_o        = byte_q;
  assign byte_valid_o  = valid_q;
  assign frame_count_o = fc_q;
  assign overflow_o    = ovf_q;
  assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mfcc_frame_packer.sv
`default_nettype none
// Bench for mfcc_frame_packer: table-driven frames plus directed overflow/reset sequences.
`timescale 1ns/1ps
module tb_mfcc_frame_packer;
  localparam int N   = 12;
  localparam int PKT = 3 + 2 * N;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dct_valid_i = 1'b0;
  logic [3:0]  ceps_ptr_i = '0;
  logic [15:0] ceps_i = '0;
  logic        dct_done_i = 1'b0;
  logic        byte_ready_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_valid_o;
  logic [15:0] frame_count_o;
  logic        overflow_o;
  logic        busy_o;

  mfcc_frame_packer #(.NUM_CEPS(N), .CEPS_WIDTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .dct_valid_i(dct_valid_i), .ceps_ptr_i(ceps_ptr_i),
    .ceps_i(ceps_i), .dct_done_i(dct_done_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i), .frame_count_o(frame_count_o), .overflow_o(overflow_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic [15:0] c [N];

  always @(posedge clk) begin
    cyc++;
    if (byte_valid_o && byte_ready_i) begin
      rx_q.push_back(byte_o);
      rx_t.push_back(cyc);
    end
  end

  typedef struct {
    logic [15:0] base;
    logic [15:0] step;
    int          stall;
    logic [7:0]  exp_seq;
    logic [7:0]  exp_chk;
    logic [15:0] exp_fc;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic clear_q();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  task automatic fill(input logic [15:0] base, input logic [15:0] step);
    for (int k = 0; k < N; k++) c[k] = base + 16'(k) * step;
  endtask

  task automatic model_packet(input logic [7:0] seq);
    logic [7:0] cs;
    cs = seq;
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(c[k][15:8]);
      exp_q.push_back(c[k][7:0]);
      cs = cs ^ c[k][15:8] ^ c[k][7:0];
    end
    exp_q.push_back(cs);
  endtask

  task automatic send_frame(input bit with_done);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      dct_valid_i = 1'b1;
      ceps_ptr_i  = 4'(k);
      ceps_i      = c[k];
      dct_done_i  = with_done && (k == N - 1);
    end
    @(negedge clk);
    dct_valid_i = 1'b0;
    dct_done_i  = 1'b0;
  endtask

  task automatic wait_rx(input string name, input int n);
    int b = 0;
    while (rx_q.size() < n && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check({name, "_rx_timeout"}, 32'(rx_q.size() >= n), 1);
  endtask

  task automatic compare_rx(input string name, input int n);
    int gaps = 0;
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
    for (int i = 1; i < rx_q.size(); i++)
      if (rx_t[i] != rx_t[i-1] + 1) gaps++;
    check({name, "_gaps"}, gaps, 0);
    clear_q();
  endtask

  task automatic wait_idle(input string name);
    int b = 0;
    while (busy_o && b < 200) begin
      @(negedge clk);
      b++;
    end
    check({name, "_idle"}, busy_o, 0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    dct_valid_i = 1'b0;
    dct_done_i = 1'b0;
    byte_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{16'h0100, 16'h0001, 0, 8'h00, 8'h00, 16'd1};
    vt[1] = '{16'h0100, 16'h0001, 5, 8'h01, 8'h01, 16'd2};
    vt[2] = '{16'h0001, 16'h0001, 0, 8'h02, 8'h0E, 16'd3};
    vt[3] = '{16'hFFFF, 16'h0000, 0, 8'h03, 8'h03, 16'd4};
    vt[4] = '{16'h1234, 16'h0101, 0, 8'h04, 8'h04, 16'd5};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte", byte_o, 0);
    check("rst_valid", byte_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_fc", frame_count_o, 0);
    rst_n = 1'b1;
    byte_ready_i = 1'b1;

    for (int v = 0; v < 5; v++) begin
      fill(vt[v].base, vt[v].step);
      model_packet(vt[v].exp_seq);
      byte_ready_i = (vt[v].stall == 0);
      send_frame(1'b1);
      check($sformatf("v%0d_launch_valid", v), byte_valid_o, 1);
      check($sformatf("v%0d_launch_sync", v), byte_o, 8'hA5);
      for (int s = 0; s < vt[v].stall; s++) begin
        @(negedge clk);
        check($sformatf("v%0d_stall_hold", v), {byte_valid_o, byte_o}, {1'b1, 8'hA5});
      end
      byte_ready_i = 1'b1;
      wait_rx($sformatf("v%0d", v), PKT);
      if (rx_q.size() >= PKT) begin
        check($sformatf("v%0d_seq", v), rx_q[1], vt[v].exp_seq);
        check($sformatf("v%0d_chk", v), rx_q[PKT-1], vt[v].exp_chk);
      end
      compare_rx($sformatf("v%0d", v), PKT);
      check($sformatf("v%0d_fc", v), frame_count_o, vt[v].exp_fc);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_idle_valid", v), byte_valid_o, 0);
    end

    // Sparse frame with an out-of-range pointer write
    reset_dut();
    @(negedge clk);
    dct_valid_i = 1'b1; ceps_ptr_i = 4'd3; ceps_i = 16'hBEEF;
    @(negedge clk);
    ceps_ptr_i = 4'd13; ceps_i = 16'h1234;
    @(negedge clk);
    dct_valid_i = 1'b0; dct_done_i = 1'b1;
    @(negedge clk);
    dct_done_i = 1'b0;
    fill(16'h0000, 16'h0000);
    c[3] = 16'hBEEF;
    model_packet(8'h00);
    wait_rx("sparse", PKT);
    if (rx_q.size() >= PKT) begin
      check("sparse_hi", rx_q[8], 8'hBE);
      check("sparse_lo", rx_q[9], 8'hEF);
      check("sparse_chk", rx_q[PKT-1], 8'h51);
    end
    compare_rx("sparse", PKT);
    wait_idle("sparse");

    // Three frames with the sink stalled: third is dropped
    reset_dut();
    byte_ready_i = 1'b0;
    fill(16'h0100, 16'h0001); model_packet(8'h00); send_frame(1'b1);
    fill(16'h2000, 16'h0011); model_packet(8'h01); send_frame(1'b1);
    fill(16'h3000, 16'h0001); send_frame(1'b1);
    check("ovf_flag", overflow_o, 1);
    check("ovf_fc", frame_count_o, 2);
    check("ovf_busy", busy_o, 1);
    byte_ready_i = 1'b1;
    wait_rx("ovf", 2 * PKT);
    compare_rx("ovf", 2 * PKT);
    wait_idle("ovf");
    check("ovf_sticky", overflow_o, 1);

    // Commit coincident with checksum acceptance
    reset_dut();
    fill(16'h0100, 16'h0001); model_packet(8'h00); send_frame(1'b1);
    fill(16'h4000, 16'h0203); model_packet(8'h01); send_frame(1'b1);
    fill(16'h7F00, 16'h0110); model_packet(8'h02); send_frame(1'b0);
    begin
      int b = 0;
      while (rx_q.size() < PKT - 1 && b < 200) begin
        @(negedge clk);
        b++;
      end
      check("coinc_align", rx_q.size(), PKT - 1);
    end
    dct_done_i = 1'b1;
    @(negedge clk);
    dct_done_i = 1'b0;
    check("coinc_ovf", overflow_o, 0);
    check("coinc_fc", frame_count_o, 3);
    wait_rx("coinc", 3 * PKT);
    compare_rx("coinc", 3 * PKT);
    wait_idle("coinc");

    // Asynchronous reset in the middle of a packet
    reset_dut();
    fill(16'h0100, 16'h0001); send_frame(1'b1);
    begin
      int b = 0;
      while (rx_q.size() < 25 && b < 200) begin
        @(negedge clk);
        b++;
      end
      check("abort_align", rx_q.size(), 25);
    end
    rst_n = 1'b0;
    #1;
    check("abort_byte", byte_o, 0);
    check("abort_valid", byte_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_fc", frame_count_o, 0);
    check("abort_ovf", overflow_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (5) @(negedge clk);
    check("abort_no_resume", rx_q.size(), 0);
    fill(16'h0100, 16'h0001); model_packet(8'h00); send_frame(1'b1);
    wait_rx("after_abort", PKT);
    compare_rx("after_abort", PKT);
    wait_idle("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
